// File: rtl/mmio_pkg.sv
// Shared command encodings, peripheral base addresses and decode helpers
// for the memory-mapped I/O controller.
package mmio_pkg;

  typedef enum logic [1:0] {
    MNONE  = 2'b00,
    MWRITE = 2'b01,
    MREAD  = 2'b10
  } mem_cmd_e;

  localparam logic [8:0] OUT_BASE  = 9'h100;
  localparam logic [8:0] IN_BASE   = 9'h140;
  localparam logic [8:0] STAT_BASE = 9'h160;

  typedef struct packed {
    logic       ram;
    logic       outr;
    logic       inp;
    logic       stat;
    logic [3:0] idx;
  } dec_t;

  // Each peripheral window is 16 slots aligned on a 16-byte boundary of the page.
  function automatic logic win_hit(input logic [7:0] off, input logic [8:0] base, input int n);
    return (off[7:4] == base[7:4]) && (int'(off[3:0]) < n);
  endfunction

endpackage

// File: rtl/mmio_in_port.sv
// One asynchronous input port: two-flop synchroniser, rising-edge detect and
// sticky status that clears on read (a same-cycle edge wins over the clear).
module mmio_in_port
  import mmio_pkg::*;
#(
  parameter int IN_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            arm_i,
  input  logic            clr_i,
  input  logic [IN_W-1:0] in_i,
  output logic [IN_W-1:0] sync_o,
  output logic [IN_W-1:0] stat_o
);

  logic [IN_W-1:0] sync1_q, sync2_q, prev_q, stat_q, stat_d, edge_w;

  assign edge_w = sync2_q & ~prev_q;
  assign stat_d = (stat_q & ~{IN_W{clr_i}}) | (edge_w & {IN_W{arm_i}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      stat_q  <= '0;
    end else begin
      sync1_q <= in_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      stat_q  <= stat_d;
    end
  end

  assign sync_o = sync2_q;
  assign stat_o = stat_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
// MMIO controller: decodes CPU accesses into RAM, N_OUT output registers and
// N_IN synchronised input ports with sticky edge status.
module mmio_io_ctrl
  import mmio_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int N_OUT  = 2,
  parameter int OUT_W  = 8,
  parameter int N_IN   = 2,
  parameter int IN_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             mem_cmd,
  input  logic [ADDR_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      write_data,
  output logic [DATA_W-1:0]      read_data,
  output logic                   ram_we,
  input  logic [DATA_W-1:0]      ram_rdata,
  input  logic [N_IN*IN_W-1:0]   in_bus,
  output logic [N_OUT*OUT_W-1:0] out_bus
);

  if (N_OUT < 1 || N_OUT > 16 || N_IN < 1 || N_IN > 16 ||
      OUT_W > DATA_W || IN_W > DATA_W || ADDR_W < 9) begin : g_param_err
    $error("mmio_io_ctrl: illegal parameter set");
  end

  // Bits between the region bit and the 256-entry page must be zero for peripherals.
  localparam logic [ADDR_W-1:0] TOP_BIT  = ADDR_W'(1) << (ADDR_W - 1);
  localparam logic [ADDR_W-1:0] MID_MASK = (TOP_BIT - ADDR_W'(1)) & ~ADDR_W'(8'hFF);

  logic                          rd_en, wr_en, periph, arm;
  logic [7:0]                    off;
  dec_t                          dec;
  logic [N_OUT-1:0][OUT_W-1:0]   out_q, out_d;
  logic [N_IN-1:0][IN_W-1:0]     sync_w, stat_w;
  logic [N_IN-1:0]               clr_w;
  logic [1:0]                    cnt_q, cnt_d;
  logic                          unused_ok;

  assign rd_en     = (mem_cmd == MREAD);
  assign wr_en     = (mem_cmd == MWRITE);
  assign off       = mem_addr[7:0];
  assign periph    = mem_addr[ADDR_W-1] && ((mem_addr & MID_MASK) == '0);
  assign unused_ok = ^write_data;

  always_comb begin
    dec      = '0;
    dec.idx  = off[3:0];
    dec.ram  = ~mem_addr[ADDR_W-1];
    dec.outr = periph && win_hit(off, OUT_BASE, N_OUT);
    dec.inp  = periph && win_hit(off, IN_BASE, N_IN);
    dec.stat = periph && win_hit(off, STAT_BASE, N_IN);
  end

  assign ram_we = wr_en && dec.ram;

  always_comb begin
    out_d = out_q;
    for (int k = 0; k < N_OUT; k++)
      if (wr_en && dec.outr && dec.idx == 4'(k)) out_d[k] = write_data[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_q <= '0;
    else        out_q <= out_d;
  end

  assign out_bus = out_q;

  // Warm-up keeps inputs that were already high at reset from reporting an edge.
  assign cnt_d = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
  assign arm   = (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  for (genvar k = 0; k < N_IN; k++) begin : g_in
    assign clr_w[k] = rd_en && dec.stat && (dec.idx == 4'(k));
    mmio_in_port #(.IN_W(IN_W)) u_port (
      .clk    (clk),
      .reset  (reset),
      .arm_i  (arm),
      .clr_i  (clr_w[k]),
      .in_i   (in_bus[k*IN_W +: IN_W]),
      .sync_o (sync_w[k]),
      .stat_o (stat_w[k])
    );
  end

  always_comb begin
    read_data = '0;
    if (rd_en) begin
      if (dec.ram) read_data = ram_rdata;
      for (int k = 0; k < N_OUT; k++)
        if (dec.outr && dec.idx == 4'(k)) read_data = DATA_W'(out_q[k]);
      for (int k = 0; k < N_IN; k++) begin
        if (dec.inp  && dec.idx == 4'(k)) read_data = DATA_W'(sync_w[k]);
        if (dec.stat && dec.idx == 4'(k)) read_data = DATA_W'(stat_w[k]);
      end
    end
  end

endmodule
